// File: rtl/ser_to_par.sv
// ser_to_par: serial-to-parallel word assembler with optional even parity.
//
// Collects a framed serial bit stream (MSB first). A frame begins with
// start_i, followed by Size data bits (qualified by bitValid_i, gaps allowed)
// and, when ParityEn = 1, one even-parity bit. A good word is presented on
// data_o with a one-cycle writeEn_o strobe. A word with a parity mismatch is
// dropped and flagged with a one-cycle parityErr_o strobe.
//
// Ports:
//   clock        in   system clock, all state changes on posedge
//   reset        in   synchronous active-high reset, highest priority
//   start_i      in   frame start strobe (also aborts a frame in progress)
//   bit_i        in   serial data bit
//   bitValid_i   in   bit_i is valid this cycle
//   data_o       out  last good assembled word (registered)
//   writeEn_o    out  one-cycle strobe, data_o is new this cycle
//   busy_o       out  frame in progress (SHIFT or PARITY)
//   parityErr_o  out  one-cycle strobe, frame dropped on parity mismatch
module ser_to_par #(
  parameter int Size     = 8,
  parameter bit ParityEn = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic            bit_i,
  input  logic            bitValid_i,
  output logic [Size-1:0] data_o,
  output logic            writeEn_o,
  output logic            busy_o,
  output logic            parityErr_o
);

  localparam int CntW = $clog2(Size + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(Size - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    EMIT   = 2'd3
  } state_e;

  // Running even parity: fold one more bit into the accumulator.
  function automatic logic parity_next(input logic par, input logic b);
    return par ^ b;
  endfunction

  // Even parity holds when the accumulated data parity plus the parity bit is 0.
  function automatic logic parity_ok(input logic par, input logic b);
    return ~(par ^ b);
  endfunction

  state_e            state_q, state_d;
  logic [Size-1:0]   shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              par_q, par_d;
  logic [Size-1:0]   data_q, data_d;
  logic              good_q, good_d;
  logic              we_q, we_d;
  logic              perr_q, perr_d;
  logic              busy_q, busy_d;

  logic [Size-1:0]   shifted_s;
  logic              last_bit_s;

  assign shifted_s  = {shift_q[Size-2:0], bit_i};
  assign last_bit_s = (cnt_q == LastBit);

  // State, datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      good_q  <= 1'b0;
      we_q    <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      good_q  <= good_d;
      we_q    <= we_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; good_d is the verdict carried into EMIT.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SHIFT;
        else         state_d = IDLE;
      end
      SHIFT: begin
        if (start_i) begin
          state_d = SHIFT;
        end else if (bitValid_i && last_bit_s) begin
          if (ParityEn) begin
            state_d = PARITY;
          end else begin
            state_d = EMIT;
            good_d  = 1'b1;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      PARITY: begin
        if (start_i) begin
          state_d = SHIFT;
        end else if (bitValid_i) begin
          state_d = EMIT;
          good_d  = parity_ok(par_q, bit_i);
        end else begin
          state_d = PARITY;
        end
      end
      EMIT: begin
        if (start_i) state_d = SHIFT;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: shift register, bit counter, running parity and output word.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else begin
          shift_d = shift_q;
        end
      end
      SHIFT: begin
        // start_i wins over a same-cycle bit: the frame restarts clean.
        if (start_i) begin
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else if (bitValid_i) begin
          shift_d = shifted_s;
          cnt_d   = cnt_q + CntW'(1);
          par_d   = parity_next(par_q, bit_i);
          // Without a parity bit the word is complete on the last data bit.
          if (!ParityEn && last_bit_s) data_d = shifted_s;
          else                         data_d = data_q;
        end else begin
          shift_d = shift_q;
        end
      end
      PARITY: begin
        if (start_i) begin
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end else if (bitValid_i && parity_ok(par_q, bit_i)) begin
          data_d = shift_q;
        end else begin
          data_d = data_q;
        end
      end
      EMIT: begin
        // Cleared unconditionally so a back-to-back frame starts clean.
        shift_d = '0;
        cnt_d   = '0;
        par_d   = 1'b0;
      end
      default: begin
        shift_d = '0;
        cnt_d   = '0;
        par_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so the strobes are registered.
  always_comb begin
    we_d   = 1'b0;
    perr_d = 1'b0;
    busy_d = 1'b0;
    if (state_d == EMIT) begin
      we_d   = good_d;
      perr_d = ~good_d;
    end else begin
      we_d   = 1'b0;
      perr_d = 1'b0;
    end
    if ((state_d == SHIFT) || (state_d == PARITY)) busy_d = 1'b1;
    else                                           busy_d = 1'b0;
  end

  assign data_o      = data_q;
  assign writeEn_o   = we_q;
  assign busy_o      = busy_q;
  assign parityErr_o = perr_q;

endmodule

// File: tb/tb_ser_to_par.sv
module tb_ser_to_par;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  // Instance A: Size=8, parity enabled
  logic       start_a = 1'b0, bit_a = 1'b0, valid_a = 1'b0;
  logic [7:0] data_a;
  logic       we_a, busy_a, perr_a;

  // Instance B: Size=4, no parity
  logic       start_b = 1'b0, bit_b = 1'b0, valid_b = 1'b0;
  logic [3:0] data_b;
  logic       we_b, busy_b, perr_b;

  int vectors = 0;
  int miscompares = 0;
  int we_count_a = 0;

  always #5 clock = ~clock;

  ser_to_par #(.Size(8), .ParityEn(1'b1)) dut_a (
    .clock(clock), .reset(reset), .start_i(start_a), .bit_i(bit_a),
    .bitValid_i(valid_a), .data_o(data_a), .writeEn_o(we_a),
    .busy_o(busy_a), .parityErr_o(perr_a)
  );

  ser_to_par #(.Size(4), .ParityEn(1'b0)) dut_b (
    .clock(clock), .reset(reset), .start_i(start_b), .bit_i(bit_b),
    .bitValid_i(valid_b), .data_o(data_b), .writeEn_o(we_b),
    .busy_o(busy_b), .parityErr_o(perr_b)
  );

  // Count write strobes of instance A, sampled away from the active edge.
  always @(negedge clock) if (we_a === 1'b1) we_count_a++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame_a();
    start_a = 1'b1; valid_a = 1'b1; bit_a = 1'b1;  // same-cycle bit is ignored
    tick();
    start_a = 1'b0; valid_a = 1'b0; bit_a = 1'b0;
  endtask

  task automatic bit_to_a(input logic b);
    valid_a = 1'b1; bit_a = b;
    tick();
    valid_a = 1'b0; bit_a = 1'b0;
  endtask

  task automatic word_to_a(input logic [7:0] w, input string tag);
    for (int i = 7; i >= 0; i--) begin
      bit_to_a(w[i]);
      chk(tag, 32'(busy_a), 32'd1);
    end
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_we",   32'(we_a),   32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_perr", 32'(perr_a), 32'd0);
    reset = 1'b0;
    tick();

    // Good word 0xA5, parity 0
    start_frame_a();
    chk("a5_busy_start", 32'(busy_a), 32'd1);
    word_to_a(8'hA5, "a5_busy");
    bit_to_a(1'b0);
    chk("a5_we",   32'(we_a),   32'd1);
    chk("a5_data", 32'(data_a), 32'hA5);
    chk("a5_perr", 32'(perr_a), 32'd0);
    chk("a5_busy_emit", 32'(busy_a), 32'd0);
    tick();
    chk("a5_we_drop", 32'(we_a), 32'd0);

    // Parity error: 0x3C with parity bit 1
    start_frame_a();
    word_to_a(8'h3C, "perr_busy");
    bit_to_a(1'b1);
    chk("perr_flag", 32'(perr_a), 32'd1);
    chk("perr_we",   32'(we_a),   32'd0);
    chk("perr_data", 32'(data_a), 32'hA5);
    tick();
    chk("perr_drop", 32'(perr_a), 32'd0);
    chk("perr_data_hold", 32'(data_a), 32'hA5);

    // Gapped 0xFF bits, abort after 5 bits, then a full 0x3C frame
    start_frame_a();
    for (int i = 0; i < 5; i++) begin
      bit_to_a(1'b1);
      repeat (i % 3 + 1) tick();
      chk("gap_busy", 32'(busy_a), 32'd1);
    end
    start_a = 1'b1; valid_a = 1'b1; bit_a = 1'b1;
    tick();
    start_a = 1'b0; valid_a = 1'b0; bit_a = 1'b0;
    chk("abort_we",   32'(we_a),   32'd0);
    chk("abort_busy", 32'(busy_a), 32'd1);
    word_to_a(8'h3C, "abort_busy2");
    bit_to_a(1'b0);
    chk("abort_3c_we",   32'(we_a),   32'd1);
    chk("abort_3c_data", 32'(data_a), 32'h3C);
    tick();
    chk("abort_we_count", 32'(we_count_a), 32'd2);

    // Back-to-back: 0x12 then 0x81, start during EMIT
    start_frame_a();
    word_to_a(8'h12, "b2b_busy1");
    bit_to_a(1'b0);
    chk("b2b_we1",   32'(we_a),   32'd1);
    chk("b2b_data1", 32'(data_a), 32'h12);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("b2b_busy_gapless", 32'(busy_a), 32'd1);
    chk("b2b_we_low",       32'(we_a),   32'd0);
    word_to_a(8'h81, "b2b_busy2");
    bit_to_a(1'b0);
    chk("b2b_we2",   32'(we_a),   32'd1);
    chk("b2b_data2", 32'(data_a), 32'h81);
    tick();
    chk("b2b_we_count", 32'(we_count_a), 32'd4);

    // Reset mid-frame after 4 bits of 0xF0
    start_frame_a();
    for (int i = 0; i < 4; i++) bit_to_a(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_data", 32'(data_a), 32'h0);
    chk("mrst_we",   32'(we_a),   32'd0);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_perr", 32'(perr_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bit_to_a(1'b0);
      chk("mrst_idle_busy", 32'(busy_a), 32'd0);
    end
    tick();
    chk("mrst_we_count", 32'(we_count_a), 32'd4);
    chk("mrst_perr_end", 32'(perr_a), 32'd0);

    // No parity, Size=4: bits 1,1,0,1 -> 0xD
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("np_busy", 32'(busy_b), 32'd1);
    valid_b = 1'b1;
    bit_b = 1'b1; tick();
    bit_b = 1'b1; tick();
    bit_b = 1'b0; tick();
    chk("np_we_early", 32'(we_b), 32'd0);
    bit_b = 1'b1; tick();
    valid_b = 1'b0; bit_b = 1'b0;
    chk("np_we",   32'(we_b),   32'd1);
    chk("np_data", 32'(data_b), 32'hD);
    chk("np_perr", 32'(perr_b), 32'd0);
    chk("np_busy_emit", 32'(busy_b), 32'd0);
    tick();
    chk("np_we_drop", 32'(we_b),   32'd0);
    chk("np_data_hold", 32'(data_b), 32'hD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ser_to_par.md
Name: ser_to_par

Overview:
- Serial-to-parallel word assembler that sits directly upstream of the generic enabled register.
- Collects a framed serial bit stream, MSB first, and checks an optional even-parity bit.
- Presents the finished word on data_o with a one-cycle writeEn_o strobe, which connect directly to the register's data_i/writeEn.
- Corrupt frames are dropped and flagged on parityErr_o.

Parameters:
- Size, 8: word width in bits; legal range is Size >= 2.
- ParityEn, 1: 1 = one even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  frame start strobe.
- bit_i  input  1  serial data bit.
- bitValid_i  input  1  bit_i is valid this cycle.
- data_o  output  Size  last good assembled word; registered.
- writeEn_o  output  1  one-cycle strobe: data_o is new this cycle.
- busy_o  output  1  a frame is in progress (state is SHIFT or PARITY).
- parityErr_o  output  1  one-cycle strobe: the frame was dropped on parity mismatch.

Behaviour:
- Reset values: data_o = 0, writeEn_o = 0, busy_o = 0, parityErr_o = 0. Internal shift register, bit counter and running parity are cleared; state = IDLE.
- Reset has priority over every other input, including mid-frame. A partial frame is discarded with no strobe.
- States: IDLE, SHIFT, PARITY, EMIT.
- IDLE:
  - start_i = 1 -> SHIFT; clear counter, shift register and parity.
  - bitValid_i is ignored, including when it arrives in the same cycle as start_i.
- SHIFT:
  - Each cycle with bitValid_i = 1: shiftReg <= {shiftReg[Size-2:0], bit_i}, counter += 1, parity ^= bit_i.
  - Cycles with bitValid_i = 0 hold all state. Gaps of any length are legal.
  - On acceptance of bit number Size: go to PARITY if ParityEn = 1, else go to EMIT.
- PARITY:
  - The first cycle with bitValid_i = 1 compares parity ^ bit_i with 0.
  - Match -> EMIT; data_o <= shiftReg on the same edge.
  - Mismatch -> EMIT with an error flag; data_o is unchanged.
- EMIT (exactly one cycle):
  - Good word: writeEn_o = 1, parityErr_o = 0.
  - Bad word: writeEn_o = 0, parityErr_o = 1.
  - Next state: IDLE, or SHIFT if start_i = 1 this cycle. The counter, shift register and parity are cleared in either case, so back-to-back frames lose no cycle.
- writeEn_o and parityErr_o are registered decodes of EMIT; they are never high together.
- data_o changes only on the edge that enters EMIT with a good word. It is stable at all other times, including across dropped frames.
- Without parity (ParityEn = 0), data_o loads on the edge that accepts the last data bit.
- Latency: writeEn_o is high in the cycle immediately after the edge that accepts the final bit (the parity bit, or the last data bit when ParityEn = 0).
- Abort: start_i = 1 while in SHIFT or PARITY restarts the frame in SHIFT with cleared counter, shift register and parity. No strobe is produced. A bitValid_i in the same cycle is ignored.
- busy_o = 1 in SHIFT and PARITY; 0 in IDLE and EMIT.
- Counter width is $clog2(Size+1). The counter never exceeds Size and does not wrap.
- Fully synchronous; no combinational path from any input to any output.

Test Plan:
- Good word, parity on: Size=8, ParityEn=1. start_i, then bits 1,0,1,0,0,1,0,1 (0xA5), then parity 0 -> EMIT cycle with writeEn_o=1, data_o=8'hA5, parityErr_o=0. busy_o=1 throughout the frame.
- Parity error: after the good 0xA5 frame, send 0x3C with parity bit 1 -> parityErr_o=1 for one cycle, writeEn_o stays 0, data_o stays 8'hA5.
- Gapped bits and abort: send 0xFF bits with random gaps of bitValid_i=0, then assert start_i after 5 bits. Follow with a full 0x3C frame with parity 0 -> single writeEn_o, data_o=8'h3C, no strobe for the aborted frame.
- Back-to-back frames: assert start_i during the EMIT cycle of a 0x12 frame (parity 0), then send 0x81 with parity 0 immediately -> two writeEn_o pulses, data_o=8'h12 then 8'h81, no idle cycle between frames.
- Reset mid-frame: assert reset after 4 bits of 0xF0 -> all outputs 0 on the next cycle, state IDLE. The remaining bits without a new start_i produce no strobe.
- No parity: Size=4, ParityEn=0. Bits 1,1,0,1 -> writeEn_o=1 in the cycle after the 4th bit, data_o=4'hD.
